ahb_mem_arbiter: RTL and testbench
==================================

Name: ahb_mem_arbiter

Overview:
- Shares the single AHB-Lite master port between instruction fetch and the rf_stage data-memory interface.
- rf_stage drives HTRANS/HWRITE/addr2Mem/data2Mem; fetch drives a simple req/addr pair.
- The arbiter selects one requester, runs one non-pipelined AHB transfer (address phase, then data phase), and returns read data with a one-cycle valid pulse.
- A starvation guard prevents rf traffic from locking out fetch.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_RF_BURST, 4, consecutive rf grants allowed while if_req is pending before fetch is forced to win (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch read request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  pulse: fetch address phase accepted
if_rdata  out  DATA_W  fetch read data, valid with if_rvalid
if_rvalid  out  1  pulse: fetch transfer complete
rf_htrans  in  2  rf request; request when rf_htrans[1]=1; held until rf_gnt
rf_hwrite  in  1  rf write (1) / read (0)
rf_addr  in  ADDR_W  rf address (addr2Mem)
rf_wdata  in  DATA_W  rf write data (data2Mem)
rf_gnt  out  1  pulse: rf address phase accepted
rf_rdata  out  DATA_W  rf read data
rf_rvalid  out  1  pulse: rf transfer complete (read or write)
HADDR  out  ADDR_W  AHB address
HTRANS  out  2  AHB transfer type: IDLE=00, NONSEQ=10 only
HWRITE  out  1  AHB write
HWDATA  out  DATA_W  AHB write data
HRDATA  in  DATA_W  AHB read data
HREADY  in  1  AHB ready
HRESP  in  1  AHB error response
bus_err  out  1  pulse with rvalid when transfer ended in error

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values (applied immediately on `rst`, and mid-transfer):
  - state=IDLE, streak=0.
  - HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0.
  - All gnt/rvalid/bus_err=0; rdata outputs=0.
  - An in-flight transfer is abandoned; no rvalid is issued for it.
- State machine (single outstanding transfer, no overlap): IDLE -> ADDR -> DATA -> IDLE. All outputs are registered.
- IDLE:
  - If either request is present at the clock edge, arbitrate.
  - Latch owner, HADDR, HWRITE (fetch: 0) and write data.
  - Go to ADDR.
  - HTRANS=00 in IDLE.
- Arbitration:
  - rf wins over fetch unless if_req=1 and streak==MAX_RF_BURST; then fetch wins.
  - streak increments on an rf grant while if_req=1, saturating at MAX_RF_BURST.
  - streak clears on a fetch grant, or on an rf grant with if_req=0.
- ADDR:
  - HTRANS=10.
  - On an edge with HREADY=1: pulse owner gnt for the next cycle, set HTRANS=00, drive HWDATA=latched data, go to DATA.
  - HREADY=0: hold all outputs.
- DATA:
  - HTRANS=00.
  - On an edge with HREADY=1: capture HRDATA into owner rdata (writes leave rdata unchanged), pulse owner rvalid for one cycle, go to IDLE.
  - If HRESP=1 on that edge: also pulse bus_err and load owner rdata with 0.
  - HRESP=1 with HREADY=0 (first error cycle): keep waiting.
- Latency: request sampled at edge N -> HTRANS=10 in cycle N+1 -> gnt pulse and data phase in cycle N+2 -> rvalid in cycle N+3 (zero wait states).
- Back-to-back: a request present during the rvalid cycle is sampled at that edge. Steady-state throughput is one transfer per 3 cycles.
- Requesters hold their inputs until gnt. Input changes after latching in IDLE are ignored.
- A requester withdrawing before being sampled is simply not served.
- gnt and rvalid are never asserted to both requesters in the same cycle.

Test Plan:
- Reset, then rf read: rf_htrans=10, rf_addr=0x100, HRDATA=0xDEADBEEF, HREADY=1 -> HTRANS=10 with HADDR=0x100 at cycle 1, rf_gnt at cycle 2, rf_rvalid with rf_rdata=0xDEADBEEF at cycle 3, if_* idle throughout.
- rf write with 2 wait states in the data phase: rf_wdata=0x12345678 -> HWDATA=0x12345678 held through the waits, HWRITE=1, rf_rvalid exactly 1 cycle after the HREADY edge.
- Simultaneous if_req and rf request sustained, MAX_RF_BURST=4 -> grant sequence rf,rf,rf,rf,if,rf,rf,rf,rf,if; fetch never starved.
- HRESP=1 in the data phase (HREADY 0 then 1) -> bus_err and if_rvalid pulse together, if_rdata=0, next request served normally.
- Assert rst while in DATA with HREADY=0 -> outputs drop to reset values asynchronously (before the next edge), no rvalid after release, fresh request completes in 3 cycles.

Source files
------------

// File: rtl/ahb_mem_arbiter_if.sv
// rtl/ahb_mem_arbiter_if.sv - requester and AHB-Lite master signal bundle for ahb_mem_arbiter
interface ahb_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rvalid;

  // rf_stage data-memory requester
  logic [1:0]        rf_htrans;
  logic              rf_hwrite;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_gnt;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_rvalid;

  // shared AHB-Lite master port
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;
  logic              bus_err;

  // arbiter side: it is the AHB master and serves both requesters
  modport master (
    input  if_req, if_addr,
    input  rf_htrans, rf_hwrite, rf_addr, rf_wdata,
    input  HRDATA, HREADY, HRESP,
    output if_gnt, if_rdata, if_rvalid,
    output rf_gnt, rf_rdata, rf_rvalid,
    output HADDR, HTRANS, HWRITE, HWDATA, bus_err
  );

  // environment side: requesters plus the AHB slave
  modport slave (
    output if_req, if_addr,
    output rf_htrans, rf_hwrite, rf_addr, rf_wdata,
    output HRDATA, HREADY, HRESP,
    input  if_gnt, if_rdata, if_rvalid,
    input  rf_gnt, rf_rdata, rf_rvalid,
    input  HADDR, HTRANS, HWRITE, HWDATA, bus_err
  );
endinterface

// File: rtl/ahb_mem_arbiter.sv
// rtl/ahb_mem_arbiter.sv - fetch / rf_stage arbiter onto one non-pipelined AHB-Lite master port
module ahb_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_RF_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  ahb_mem_arbiter_if.master  bus
);

  localparam int STREAK_W = (MAX_RF_BURST < 1) ? 1 : $clog2(MAX_RF_BURST + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RF_BURST);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10
  } state_t;

  typedef enum logic {
    OWN_RF = 1'b0,
    OWN_IF = 1'b1
  } owner_t;

  state_t              state_q,    state_d;
  owner_t              owner_q,    owner_d;
  logic [STREAK_W-1:0] streak_q,   streak_d;
  logic [ADDR_W-1:0]   haddr_q,    haddr_d;
  logic [1:0]          htrans_q,   htrans_d;
  logic                hwrite_q,   hwrite_d;
  logic [DATA_W-1:0]   hwdata_q,   hwdata_d;
  logic [DATA_W-1:0]   wdata_q,    wdata_d;
  logic                if_gnt_q,   if_gnt_d;
  logic                rf_gnt_q,   rf_gnt_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                rf_rvalid_q, rf_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   rf_rdata_q, rf_rdata_d;
  logic                bus_err_q,  bus_err_d;

  logic rf_req;
  logic force_if;
  logic unused_htrans0;

  // only HTRANS[1] distinguishes a real rf request; SEQ and NONSEQ are treated alike
  assign rf_req         = bus.rf_htrans[1];
  assign unused_htrans0 = bus.rf_htrans[0];

  // fetch has waited through a full rf streak and must win this round
  assign force_if = bus.if_req && (streak_q == STREAK_MAX);

  // next-state and next-output computation for the IDLE -> ADDR -> DATA transfer sequence
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    rf_rdata_d  = rf_rdata_q;
    if_gnt_d    = 1'b0;
    rf_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    rf_rvalid_d = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        htrans_d = HTRANS_IDLE;
        if (rf_req && !force_if) begin
          owner_d  = OWN_RF;
          haddr_d  = bus.rf_addr;
          hwrite_d = bus.rf_hwrite;
          wdata_d  = bus.rf_wdata;
          htrans_d = HTRANS_NONSEQ;
          state_d  = S_ADDR;
          // streak only grows while fetch is actually being held off
          if (bus.if_req) begin
            if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end else begin
            streak_d = '0;
          end
        end else if (bus.if_req) begin
          owner_d  = OWN_IF;
          haddr_d  = bus.if_addr;
          hwrite_d = 1'b0;
          wdata_d  = '0;
          htrans_d = HTRANS_NONSEQ;
          state_d  = S_ADDR;
          streak_d = '0;
        end
      end

      S_ADDR: begin
        if (bus.HREADY) begin
          if (owner_q == OWN_IF) begin
            if_gnt_d = 1'b1;
          end else begin
            rf_gnt_d = 1'b1;
          end
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
          state_d  = S_DATA;
        end
      end

      S_DATA: begin
        htrans_d = HTRANS_IDLE;
        if (bus.HREADY) begin
          bus_err_d = bus.HRESP;
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.HRESP ? '0 : bus.HRDATA;
          end else begin
            rf_rvalid_d = 1'b1;
            if (bus.HRESP) begin
              rf_rdata_d = '0;
            end else if (!hwrite_q) begin
              rf_rdata_d = bus.HRDATA;
            end
          end
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d  = S_IDLE;
        htrans_d = HTRANS_IDLE;
      end
    endcase
  end

  // state and registered outputs; reset abandons any in-flight transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_RF;
      streak_q    <= '0;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      wdata_q     <= '0;
      if_gnt_q    <= 1'b0;
      rf_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      rf_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      rf_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
      if_gnt_q    <= if_gnt_d;
      rf_gnt_q    <= rf_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      rf_rvalid_q <= rf_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      rf_rdata_q  <= rf_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.HADDR     = haddr_q;
  assign bus.HTRANS    = htrans_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HWDATA    = hwdata_q;
  assign bus.if_gnt    = if_gnt_q;
  assign bus.rf_gnt    = rf_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.rf_rvalid = rf_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.rf_rdata  = rf_rdata_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// tb/tb_ahb_mem_arbiter.sv - directed self-checking bench for ahb_mem_arbiter
module tb_ahb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ahb_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_RF_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [9:0] exp_seq;
    int         ngnt;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.rf_htrans = 2'b00;
    bus.rf_hwrite = 1'b0;
    bus.rf_addr   = '0;
    bus.rf_wdata  = '0;
    bus.HRDATA    = '0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_htrans", {30'b0, bus.HTRANS}, 32'h0);
    chk("rst_haddr", bus.HADDR, 32'h0);
    chk("rst_hwrite", {31'b0, bus.HWRITE}, 32'h0);
    chk("rst_hwdata", bus.HWDATA, 32'h0);
    chk("rst_gnts", {30'b0, bus.if_gnt, bus.rf_gnt}, 32'h0);
    chk("rst_rvalids", {29'b0, bus.if_rvalid, bus.rf_rvalid, bus.bus_err}, 32'h0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_rf_rdata", bus.rf_rdata, 32'h0);
    rst = 1'b0;

    // rf read, zero wait states
    bus.rf_htrans = 2'b10;
    bus.rf_addr   = 32'h100;
    bus.HRDATA    = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_c1_htrans", {30'b0, bus.HTRANS}, 32'h2);
    chk("rd_c1_haddr", bus.HADDR, 32'h100);
    chk("rd_c1_hwrite", {31'b0, bus.HWRITE}, 32'h0);
    chk("rd_c1_gnts", {30'b0, bus.if_gnt, bus.rf_gnt}, 32'h0);
    @(negedge clk);
    chk("rd_c2_gnts", {30'b0, bus.if_gnt, bus.rf_gnt}, 32'h1);
    chk("rd_c2_htrans", {30'b0, bus.HTRANS}, 32'h0);
    bus.rf_htrans = 2'b00;
    @(negedge clk);
    chk("rd_c3_rvalids", {29'b0, bus.if_rvalid, bus.rf_rvalid, bus.bus_err}, 32'h2);
    chk("rd_c3_rdata", bus.rf_rdata, 32'hDEADBEEF);
    chk("rd_c3_gnts", {30'b0, bus.if_gnt, bus.rf_gnt}, 32'h0);
    @(negedge clk);
    chk("rd_c4_rvalids", {29'b0, bus.if_rvalid, bus.rf_rvalid, bus.bus_err}, 32'h0);
    chk("rd_c4_htrans", {30'b0, bus.HTRANS}, 32'h0);

    // rf write with two data-phase wait states
    bus.rf_htrans = 2'b10;
    bus.rf_hwrite = 1'b1;
    bus.rf_addr   = 32'h200;
    bus.rf_wdata  = 32'h12345678;
    @(negedge clk);
    chk("wr_c1_htrans", {30'b0, bus.HTRANS}, 32'h2);
    chk("wr_c1_hwrite", {31'b0, bus.HWRITE}, 32'h1);
    chk("wr_c1_haddr", bus.HADDR, 32'h200);
    @(negedge clk);
    chk("wr_c2_rf_gnt", {31'b0, bus.rf_gnt}, 32'h1);
    chk("wr_c2_hwdata", bus.HWDATA, 32'h12345678);
    bus.rf_htrans = 2'b00;
    bus.rf_wdata  = 32'hFFFF0000;
    bus.HREADY    = 1'b0;
    @(negedge clk);
    chk("wr_w1_rvalid", {31'b0, bus.rf_rvalid}, 32'h0);
    chk("wr_w1_rf_gnt", {31'b0, bus.rf_gnt}, 32'h0);
    chk("wr_w1_hwdata", bus.HWDATA, 32'h12345678);
    @(negedge clk);
    chk("wr_w2_rvalid", {31'b0, bus.rf_rvalid}, 32'h0);
    chk("wr_w2_hwdata", bus.HWDATA, 32'h12345678);
    chk("wr_w2_hwrite", {31'b0, bus.HWRITE}, 32'h1);
    bus.HREADY = 1'b1;
    @(negedge clk);
    chk("wr_done_rvalid", {31'b0, bus.rf_rvalid}, 32'h1);
    chk("wr_done_rdata_kept", bus.rf_rdata, 32'hDEADBEEF);
    chk("wr_done_err", {31'b0, bus.bus_err}, 32'h0);
    @(negedge clk);
    chk("wr_after_rvalid", {31'b0, bus.rf_rvalid}, 32'h0);
    bus.rf_hwrite = 1'b0;

    // sustained contention: expect rf x4, if, rf x4, if
    exp_seq = 10'b10_0001_0000;
    ngnt    = 0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h400;
    bus.rf_htrans = 2'b10;
    bus.rf_addr   = 32'h300;
    for (int c = 0; c < 60 && ngnt < 10; c++) begin
      @(negedge clk);
      if (bus.if_gnt && bus.rf_gnt) begin
        chk("fair_both_gnt", 32'h1, 32'h0);
      end
      if (bus.if_gnt || bus.rf_gnt) begin
        chk($sformatf("fair_gnt%0d_is_if", ngnt), {31'b0, bus.if_gnt}, {31'b0, exp_seq[ngnt]});
        ngnt++;
      end
    end
    chk("fair_gnt_count", ngnt, 32'd10);
    bus.if_req    = 1'b0;
    bus.rf_htrans = 2'b00;
    @(negedge clk);
    chk("fair_last_if_rvalid", {31'b0, bus.if_rvalid}, 32'h1);
    @(negedge clk);

    // fetch read ending in an error response after one wait cycle
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h500;
    bus.HRDATA  = 32'hCAFEF00D;
    @(negedge clk);
    chk("err_c1_htrans", {30'b0, bus.HTRANS}, 32'h2);
    chk("err_c1_haddr", bus.HADDR, 32'h500);
    chk("err_c1_hwrite", {31'b0, bus.HWRITE}, 32'h0);
    @(negedge clk);
    chk("err_c2_if_gnt", {30'b0, bus.if_gnt, bus.rf_gnt}, 32'h2);
    bus.if_req = 1'b0;
    bus.HREADY = 1'b0;
    bus.HRESP  = 1'b1;
    @(negedge clk);
    chk("err_wait_rvalid_err", {29'b0, bus.if_rvalid, bus.rf_rvalid, bus.bus_err}, 32'h0);
    bus.HREADY = 1'b1;
    @(negedge clk);
    chk("err_done_rvalid_err", {29'b0, bus.if_rvalid, bus.rf_rvalid, bus.bus_err}, 32'h5);
    chk("err_done_if_rdata", bus.if_rdata, 32'h0);
    bus.HRESP = 1'b0;
    @(negedge clk);
    chk("err_after_err", {31'b0, bus.bus_err}, 32'h0);
    bus.rf_htrans = 2'b10;
    bus.rf_addr   = 32'h600;
    bus.HRDATA    = 32'h0BADCAFE;
    @(negedge clk);
    chk("post_err_htrans", {30'b0, bus.HTRANS}, 32'h2);
    @(negedge clk);
    chk("post_err_rf_gnt", {31'b0, bus.rf_gnt}, 32'h1);
    bus.rf_htrans = 2'b00;
    @(negedge clk);
    chk("post_err_rvalid", {29'b0, bus.if_rvalid, bus.rf_rvalid, bus.bus_err}, 32'h2);
    chk("post_err_rdata", bus.rf_rdata, 32'h0BADCAFE);
    @(negedge clk);

    // asynchronous reset during a stalled data phase
    bus.rf_htrans = 2'b10;
    bus.rf_addr   = 32'h700;
    @(negedge clk);
    chk("ar_c1_haddr", bus.HADDR, 32'h700);
    @(negedge clk);
    chk("ar_c2_rf_gnt", {31'b0, bus.rf_gnt}, 32'h1);
    bus.rf_htrans = 2'b00;
    bus.HREADY    = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("ar_async_rf_gnt", {31'b0, bus.rf_gnt}, 32'h0);
    chk("ar_async_haddr", bus.HADDR, 32'h0);
    chk("ar_async_rf_rdata", bus.rf_rdata, 32'h0);
    chk("ar_async_htrans", {30'b0, bus.HTRANS}, 32'h0);
    @(negedge clk);
    rst        = 1'b0;
    bus.HREADY = 1'b1;
    @(negedge clk);
    chk("ar_no_rvalid_1", {29'b0, bus.if_rvalid, bus.rf_rvalid, bus.bus_err}, 32'h0);
    @(negedge clk);
    chk("ar_no_rvalid_2", {29'b0, bus.if_rvalid, bus.rf_rvalid, bus.bus_err}, 32'h0);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h800;
    bus.HRDATA  = 32'h11223344;
    @(negedge clk);
    chk("ar_new_htrans", {30'b0, bus.HTRANS}, 32'h2);
    chk("ar_new_haddr", bus.HADDR, 32'h800);
    @(negedge clk);
    chk("ar_new_if_gnt", {30'b0, bus.if_gnt, bus.rf_gnt}, 32'h2);
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("ar_new_rvalid", {29'b0, bus.if_rvalid, bus.rf_rvalid, bus.bus_err}, 32'h4);
    chk("ar_new_if_rdata", bus.if_rdata, 32'h11223344);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
